// File: rtl/address_unit.sv
// Address unit: PCRA0/PCRA1 program counters, SP/SI/DI pointers, active-PC flag.
// Latency: address and pointer-byte outputs are combinational; register updates land on the next clk edge.
// Backpressure: none; every load, increment and flip request is applied in the cycle it is presented.
// Optional build macro ADDR_UNIT_SP_DEC_EN adds the sp_dec input (SP decrement).
module address_unit #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bus_in,
  input  logic [2:0]            ptr_load_select,
  input  logic [2:0]            ptr_assert_select,
  input  logic [1:0]            spsidi_inc_select,
  input  logic [2:0]            addr_select,
  input  logic                  inc_pcra0,
  input  logic                  inc_pcra1,
  input  logic                  pcra_flip,
  input  logic                  pcra_load,
  input  logic [ADDR_WIDTH-1:0] tx_in,
`ifdef ADDR_UNIT_SP_DEC_EN
  input  logic                  sp_dec,
`endif
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_out_en,
  output logic                  pcra_active
);

  // Upper pointer byte width; the hi byte takes the low HI_W bits of bus_in.
  localparam int HI_W = ADDR_WIDTH - WIDTH;

  logic [ADDR_WIDTH-1:0] pcra0, pcra1, sp, si, di;
  logic [ADDR_WIDTH-1:0] pcra0_nxt, pcra1_nxt, sp_nxt, si_nxt, di_nxt;
  logic                  pcra_active_nxt;
  logic                  dec_sp;

`ifdef ADDR_UNIT_SP_DEC_EN
  assign dec_sp = sp_dec;
`else
  assign dec_sp = 1'b0;
`endif

  // Byte load beats any increment/decrement; inc and dec together cancel.
  function automatic logic [ADDR_WIDTH-1:0] ptr_next(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic                  ld_lo,
    input logic                  ld_hi,
    input logic                  inc,
    input logic                  dec,
    input logic [WIDTH-1:0]      d
  );
    logic [ADDR_WIDTH-1:0] r;
    r = cur;
    if (ld_lo)
      r = {cur[ADDR_WIDTH-1:WIDTH], d};
    else if (ld_hi)
      r = {d[HI_W-1:0], cur[WIDTH-1:0]};
    else if (inc && !dec)
      r = cur + ADDR_WIDTH'(1);
    else if (dec && !inc)
      r = cur - ADDR_WIDTH'(1);
    return r;
  endfunction

  // Next-state for pointers, program counters and the active-PC flag.
  always_comb begin
    sp_nxt = ptr_next(sp, ptr_load_select == 3'd1, ptr_load_select == 3'd2,
                      spsidi_inc_select == 2'd1, dec_sp, bus_in);
    si_nxt = ptr_next(si, ptr_load_select == 3'd3, ptr_load_select == 3'd4,
                      spsidi_inc_select == 2'd2, 1'b0, bus_in);
    di_nxt = ptr_next(di, ptr_load_select == 3'd5, ptr_load_select == 3'd6,
                      spsidi_inc_select == 2'd3, 1'b0, bus_in);

    // pcra_load targets the PC that is inactive before this edge.
    pcra0_nxt = pcra0;
    if (pcra_load && pcra_active)
      pcra0_nxt = tx_in;
    else if (inc_pcra0)
      pcra0_nxt = pcra0 + ADDR_WIDTH'(1);

    pcra1_nxt = pcra1;
    if (pcra_load && !pcra_active)
      pcra1_nxt = tx_in;
    else if (inc_pcra1)
      pcra1_nxt = pcra1 + ADDR_WIDTH'(1);

    pcra_active_nxt = pcra_active ^ pcra_flip;
  end

  // State registers with synchronous reset overriding every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcra0       <= '0;
      pcra1       <= '0;
      sp          <= '0;
      si          <= '0;
      di          <= '0;
      pcra_active <= 1'b0;
    end else begin
      pcra0       <= pcra0_nxt;
      pcra1       <= pcra1_nxt;
      sp          <= sp_nxt;
      si          <= si_nxt;
      di          <= di_nxt;
      pcra_active <= pcra_active_nxt;
    end
  end

  // Address and pointer-byte muxes from pre-edge register state; zero when unselected.
  always_comb begin
    addr_out   = '0;
    addr_valid = 1'b1;
    case (addr_select)
      3'd1:    addr_out = pcra0;
      3'd2:    addr_out = pcra1;
      3'd3:    addr_out = sp;
      3'd4:    addr_out = si;
      3'd5:    addr_out = di;
      3'd6:    addr_out = tx_in;
      default: addr_valid = 1'b0;
    endcase

    bus_out    = '0;
    bus_out_en = 1'b1;
    case (ptr_assert_select)
      3'd1:    bus_out = sp[WIDTH-1:0];
      3'd2:    bus_out = WIDTH'(sp[ADDR_WIDTH-1:WIDTH]);
      3'd3:    bus_out = si[WIDTH-1:0];
      3'd4:    bus_out = WIDTH'(si[ADDR_WIDTH-1:WIDTH]);
      3'd5:    bus_out = di[WIDTH-1:0];
      3'd6:    bus_out = WIDTH'(di[ADDR_WIDTH-1:WIDTH]);
      default: bus_out_en = 1'b0;
    endcase
  end

endmodule
